executor_place: RTL and testbench
=================================

// Module: executor_place
// PURPOSE
//  Locks a falling tetromino into the matrix memory; the write-side counterpart of the line-clear executor.
//  Tests a 4x4 piece at (x,y) against the board. In commit mode it ORs the piece into the board and launches line-clear.
//  Sits between game control and the matrix memory. The top level muxes memory ports; one executor owns them at a time.
// PARAMETERS
//  width_p   16  board columns = matrix memory row width
//  height_p  32  board rows = matrix memory depth; row 0 top, row height_p-1 bottom
// PORTS
//  clk_i            in   1                     clock
//  reset_n_i        in   1                     asynchronous active-low reset
//  v_i              in   1                     request valid; accepted when v_i && ready_o
//  ready_o          out  1                     idle, can accept
//  commit_i         in   1                     1 = place piece if legal, 0 = collision test only
//  piece_i          in   16                    piece_i[4*r+c] = piece row r, col c
//  x_i              in   $clog2(width_p)+1     signed board column of piece col 0
//  y_i              in   $clog2(height_p)+1    signed board row of piece row 0
//  done_o           out  1                     one-cycle completion pulse
//  collide_o        out  1                     collision result, valid while done_o
//  check_v_o        out  1                     one-cycle start pulse to line-clear executor (= done_o && committed)
//  mm_read_addr_o   out  $clog2(height_p)      combinational-read address
//  mm_read_data_i   in   width_p               row data, same cycle as address
//  mm_write_addr_o  out  $clog2(height_p)      write address
//  mm_write_data_o  out  width_p               write data
//  mm_write_v_o     out  1                     write strobe, written at clock edge
// BEHAVIOUR
//  - Reset values: state eIDLE; ready_o=1; done_o, collide_o, check_v_o, mm_write_v_o = 0; addresses and data 0.
//  - Request handling: on accept, register piece_i, x_i, y_i, commit_i. Clear the collision flag and row counter r.
//  - States:
//    eIDLE -> eScan on accept.
//    eScan: r=0..3, one row per cycle, then r==3 goes to eWrite if commit && !collide, else eDone.
//    eWrite: r=0..3, one row per cycle, then eDone.
//    eDone: one cycle, then eIDLE.
//  - Row mask: mask = zero-extended piece row r << x, computed at width_p+4 bits. Negative x shifts right.
//  - Out of range: a piece bit landing at col < 0 or col >= width_p counts as a collision.
//  - Row index = y+r:
//    row >= height_p with any piece bit -> collision.
//    row < 0 -> ignored, no collision (spawn above board allowed); on commit those bits are dropped.
//  - eScan: read address = row if 0..height_p-1, else 0. collide |= |(mask & mm_read_data_i) for in-range nonempty rows.
//  - eWrite: read and write the same address, write data = mm_read_data_i | mask.
//    mm_write_v_o=1 only for in-range rows with nonzero mask. Empty or out-of-range rows still take one cycle.
//  - Fixed latency, accept edge = T:
//    test or collision: eScan T+1..T+4, done_o at T+5.
//    commit: eWrite T+5..T+8, done_o at T+9.
//  - eDone: done_o=1; collide_o=final flag; check_v_o=commit && !collide. ready_o=1 only in eIDLE.
//  - Requests: v_i while busy is ignored; there is no queueing.
//  - Reset mid-operation: immediate return to reset values. mm_write_v_o drops in the same cycle.
//    Rows already written stay written; recovery is top-level policy.
// STRUCTURE
//  - Shared package executor_pkg:
//    typedef piece_t (logic [15:0]);
//    state enum {eIDLE, eScan, eWrite, eDone};
//    constant piece_dim_c = 4.
//  - One sub-module piece_row_shifter (combinational): 4-bit row + signed x -> width_p mask + overflow flag.
//  - Top level: FSM, row counter, registered request, memory port drive.
// TESTING
//  1 Empty board, piece 16'h0066, x=0, y=30, commit=1 -> writes row30=row31=16'h0006 at T+5..T+8. done_o at T+9, collide_o=0, check_v_o=1.
//  2 Same, y=31 -> piece row 1 lands on row 32 -> collide_o=1 at T+5, mm_write_v_o never 1, check_v_o=0.
//  3 16'h0066, y=30: x=-1 -> mask 16'h0003, no collision. x=-2 -> col -1 -> collide_o=1.
//  4 Row 31 preloaded 16'h0002, 16'h0066 at x=0, y=30, commit -> collide_o=1, no writes, done_o at T+5.
//  5 Empty board, commit=0, legal piece -> done_o at T+5, collide_o=0, no writes, check_v_o=0. v_i during T+1..T+4 ignored.
//  6 reset_n_i low during second eWrite cycle -> all outputs at reset values that cycle. ready_o=1 after release, row 30 keeps written value.

Source files
------------

// File: rtl/executor_pkg.sv
// Shared types and constants for the matrix-memory executors.
package executor_pkg;
  typedef logic [15:0] piece_t;
  typedef logic [1:0]  state_t;

  localparam state_t eIDLE  = 2'd0;
  localparam state_t eScan  = 2'd1;
  localparam state_t eWrite = 2'd2;
  localparam state_t eDone  = 2'd3;

  localparam int unsigned piece_dim_c = 4;
endpackage

// File: rtl/executor_place_if.sv
// Request/response handshake and matrix-memory port of the place executor.
interface executor_place_if #(
  parameter int unsigned width_p  = 16,
  parameter int unsigned height_p = 32
);
  import executor_pkg::*;

  localparam int unsigned x_w_c = $clog2(width_p) + 1;
  localparam int unsigned y_w_c = $clog2(height_p) + 1;
  localparam int unsigned a_w_c = $clog2(height_p);

  logic                    v_i;
  logic                    ready_o;
  logic                    commit_i;
  piece_t                  piece_i;
  logic signed [x_w_c-1:0] x_i;
  logic signed [y_w_c-1:0] y_i;
  logic                    done_o;
  logic                    collide_o;
  logic                    check_v_o;
  logic [a_w_c-1:0]        mm_read_addr_o;
  logic [width_p-1:0]      mm_read_data_i;
  logic [a_w_c-1:0]        mm_write_addr_o;
  logic [width_p-1:0]      mm_write_data_o;
  logic                    mm_write_v_o;

  modport slave (
    input  v_i, commit_i, piece_i, x_i, y_i, mm_read_data_i,
    output ready_o, done_o, collide_o, check_v_o,
           mm_read_addr_o, mm_write_addr_o, mm_write_data_o, mm_write_v_o
  );

  modport master (
    output v_i, commit_i, piece_i, x_i, y_i, mm_read_data_i,
    input  ready_o, done_o, collide_o, check_v_o,
           mm_read_addr_o, mm_write_addr_o, mm_write_data_o, mm_write_v_o
  );
endinterface

// File: rtl/executor_place_shifter.sv
// Places one 4-bit piece row at signed column x; flags bits that fall off either board edge.
module piece_row_shifter
  import executor_pkg::*;
#(
  parameter  int unsigned width_p = 16,
  localparam int unsigned x_w_c   = $clog2(width_p) + 1
) (
  input  logic [piece_dim_c-1:0] row,
  input  logic signed [x_w_c-1:0] x,
  output logic [width_p-1:0]     mask,
  output logic                   overflow
);
  localparam int unsigned ext_w_c = width_p + piece_dim_c;

  logic [ext_w_c-1:0] ext;
  logic [ext_w_c-1:0] shl;
  logic [ext_w_c-1:0] drop;
  logic [width_p-1:0] shr;
  logic [x_w_c-1:0]   mag;

  always_comb begin
    ext  = ext_w_c'(row);
    mag  = x[x_w_c-1] ? $unsigned(-x) : $unsigned(x);
    shl  = ext << mag;
    shr  = width_p'(ext >> mag);
    // bits shifted below column 0 on a negative x
    drop = ext & ~({ext_w_c{1'b1}} << mag);
    if (x[x_w_c-1]) begin
      mask     = shr;
      overflow = |drop;
    end else begin
      mask     = shl[width_p-1:0];
      overflow = |shl[ext_w_c-1:width_p];
    end
  end
endmodule

// File: rtl/executor_place.sv
// Tests a 4x4 piece against the board and, on commit, ORs it into matrix memory.
module executor_place
  import executor_pkg::*;
#(
  parameter int unsigned width_p  = 16,
  parameter int unsigned height_p = 32
) (
  input logic             clk_i,
  input logic             reset_n_i,
  executor_place_if.slave bus
);
  localparam int unsigned x_w_c   = $clog2(width_p) + 1;
  localparam int unsigned y_w_c   = $clog2(height_p) + 1;
  localparam int unsigned a_w_c   = $clog2(height_p);
  localparam int unsigned row_w_c = y_w_c + 1;
  localparam int unsigned r_w_c   = $clog2(piece_dim_c);

  state_t                  state_q, state_d;
  logic [r_w_c-1:0]        r_q, r_d;
  piece_t                  piece_q;
  logic signed [x_w_c-1:0] x_q;
  logic signed [y_w_c-1:0] y_q;
  logic                    commit_q;
  logic                    collide_q, collide_d;
  logic                    ready_q, done_q, collide_out_q, check_v_q;

  logic [piece_dim_c-1:0]    prow;
  logic [width_p-1:0]        mask;
  logic                      ovf;
  logic signed [row_w_c-1:0] row;
  logic                      row_in, row_high;
  logic [a_w_c-1:0]          addr;
  logic                      scan_hit;

  assign prow = piece_q[{r_q, 2'b00} +: piece_dim_c];

  piece_row_shifter #(.width_p(width_p)) u_shift (
    .row      (prow),
    .x        (x_q),
    .mask     (mask),
    .overflow (ovf)
  );

  // Board row under the current piece row; negative rows are above the board.
  assign row      = row_w_c'(y_q) + $signed({{(row_w_c-r_w_c){1'b0}}, r_q});
  assign row_in   = !row[row_w_c-1] && (row[row_w_c-2:0] < (row_w_c-1)'(height_p));
  assign row_high = !row[row_w_c-1] && !row_in;
  assign addr     = row_in ? row[a_w_c-1:0] : '0;

  always_comb begin
    scan_hit = 1'b0;
    if (row_in)        scan_hit = ovf | (|(mask & bus.mm_read_data_i));
    else if (row_high) scan_hit = |prow;
  end

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    collide_d = collide_q;
    case (state_q)
      eIDLE: begin
        if (bus.v_i) begin
          state_d   = eScan;
          r_d       = '0;
          collide_d = 1'b0;
        end
      end
      eScan: begin
        collide_d = collide_q | scan_hit;
        r_d       = r_q + r_w_c'(1);
        if (r_q == r_w_c'(piece_dim_c - 1))
          state_d = (commit_q && !collide_d) ? eWrite : eDone;
      end
      eWrite: begin
        r_d = r_q + r_w_c'(1);
        if (r_q == r_w_c'(piece_dim_c - 1)) state_d = eDone;
      end
      eDone:   state_d = eIDLE;
      default: state_d = eIDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= eIDLE;
      r_q           <= '0;
      piece_q       <= '0;
      x_q           <= '0;
      y_q           <= '0;
      commit_q      <= 1'b0;
      collide_q     <= 1'b0;
      ready_q       <= 1'b1;
      done_q        <= 1'b0;
      collide_out_q <= 1'b0;
      check_v_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      r_q           <= r_d;
      collide_q     <= collide_d;
      ready_q       <= (state_d == eIDLE);
      done_q        <= (state_d == eDone);
      collide_out_q <= (state_d == eDone) && collide_d;
      check_v_q     <= (state_d == eDone) && commit_q && !collide_d;
      if (state_q == eIDLE && bus.v_i) begin
        piece_q  <= bus.piece_i;
        x_q      <= bus.x_i;
        y_q      <= bus.y_i;
        commit_q <= bus.commit_i;
      end
    end
  end

  assign bus.ready_o   = ready_q;
  assign bus.done_o    = done_q;
  assign bus.collide_o = collide_out_q;
  assign bus.check_v_o = check_v_q;

  // Memory reads return in the same cycle, so the port is decoded from registered state.
  assign bus.mm_read_addr_o  = (state_q == eScan || state_q == eWrite) ? addr : '0;
  assign bus.mm_write_addr_o = (state_q == eWrite) ? addr : '0;
  assign bus.mm_write_data_o = (state_q == eWrite) ? (bus.mm_read_data_i | mask) : '0;
  assign bus.mm_write_v_o    = (state_q == eWrite) && row_in && (|mask);
endmodule

// File: tb/tb_executor_place.sv
// Directed bench for executor_place with a behavioural matrix memory.
module tb_executor_place;
  logic clk_i;
  logic reset_n_i;

  executor_place_if bus ();

  executor_place dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .bus       (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [15:0] mem [32];
  logic        pre_v, pre_clr;
  logic [4:0]  pre_addr;
  logic [15:0] pre_data;

  assign bus.mm_read_data_i = mem[bus.mm_read_addr_o];

  always @(posedge clk_i) begin
    if (pre_clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (pre_v) begin
      mem[pre_addr] <= pre_data;
    end else if (bus.mm_write_v_o) begin
      mem[bus.mm_write_addr_o] <= bus.mm_write_data_o;
    end
  end

  int tests = 0;
  int fails = 0;

  int          nwr, done_cyc, busy_ready;
  logic        col_s, chk_s;
  logic [4:0]  wa [4];
  logic [15:0] wd [4];
  int          wc [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_board();
    pre_clr = 1'b1;
    @(posedge clk_i); #1;
    pre_clr = 1'b0;
  endtask

  task automatic preload(input logic [4:0] a, input logic [15:0] d);
    pre_v = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk_i); #1;
    pre_v = 1'b0;
  endtask

  // Issues one request and records what the DUT does until done_o (cycle 1 = first after accept).
  task automatic run_op(input logic c, input logic [15:0] p, input logic signed [4:0] x,
                        input logic signed [5:0] y, input logic hold);
    nwr = 0; done_cyc = 0; busy_ready = 0; col_s = 1'b0; chk_s = 1'b0;
    for (int i = 0; i < 4; i++) begin wa[i] = '0; wd[i] = '0; wc[i] = 0; end
    bus.v_i = 1'b1; bus.commit_i = c; bus.piece_i = p; bus.x_i = x; bus.y_i = y;
    @(posedge clk_i); #1;
    if (!hold) bus.v_i = 1'b0;
    for (int cyc = 1; cyc <= 20 && done_cyc == 0; cyc++) begin
      if (bus.mm_write_v_o) begin
        if (nwr < 4) begin
          wa[nwr] = bus.mm_write_addr_o; wd[nwr] = bus.mm_write_data_o; wc[nwr] = cyc;
        end
        nwr++;
      end
      if (bus.done_o) begin
        done_cyc = cyc; col_s = bus.collide_o; chk_s = bus.check_v_o;
      end else if (bus.ready_o) begin
        busy_ready = 1;
      end
      @(posedge clk_i); #1;
    end
    bus.v_i = 1'b0;
  endtask

  initial begin
    reset_n_i = 1'b0;
    bus.v_i = 1'b0; bus.commit_i = 1'b0; bus.piece_i = '0; bus.x_i = '0; bus.y_i = '0;
    pre_v = 1'b0; pre_clr = 1'b1; pre_addr = '0; pre_data = '0;
    repeat (2) @(posedge clk_i);
    #1;
    pre_clr = 1'b0;
    check("rst_ready", 32'(bus.ready_o), 32'd1);
    check("rst_done", 32'(bus.done_o), 32'd0);
    check("rst_collide", 32'(bus.collide_o), 32'd0);
    check("rst_check_v", 32'(bus.check_v_o), 32'd0);
    check("rst_write_v", 32'(bus.mm_write_v_o), 32'd0);
    check("rst_raddr", 32'(bus.mm_read_addr_o), 32'd0);
    check("rst_waddr", 32'(bus.mm_write_addr_o), 32'd0);
    check("rst_wdata", 32'(bus.mm_write_data_o), 32'd0);
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;

    // Legal commit at the bottom of an empty board
    run_op(1'b1, 16'h0066, 5'sd0, 6'sd30, 1'b0);
    check("t1_done_cyc", 32'(done_cyc), 32'd9);
    check("t1_collide", 32'(col_s), 32'd0);
    check("t1_check_v", 32'(chk_s), 32'd1);
    check("t1_nwr", 32'(nwr), 32'd2);
    check("t1_wa0", 32'(wa[0]), 32'd30);
    check("t1_wd0", 32'(wd[0]), 32'h0006);
    check("t1_wc0", 32'(wc[0]), 32'd5);
    check("t1_wa1", 32'(wa[1]), 32'd31);
    check("t1_wd1", 32'(wd[1]), 32'h0006);
    check("t1_wc1", 32'(wc[1]), 32'd6);
    check("t1_mem30", 32'(mem[30]), 32'h0006);
    check("t1_mem31", 32'(mem[31]), 32'h0006);
    check("t1_ready_after", 32'(bus.ready_o), 32'd1);

    // Piece row 1 below the floor
    clear_board();
    run_op(1'b1, 16'h0066, 5'sd0, 6'sd31, 1'b0);
    check("t2_done_cyc", 32'(done_cyc), 32'd5);
    check("t2_collide", 32'(col_s), 32'd1);
    check("t2_check_v", 32'(chk_s), 32'd0);
    check("t2_nwr", 32'(nwr), 32'd0);

    // Negative x: legal at -1, off the left edge at -2
    clear_board();
    run_op(1'b0, 16'h0066, -5'sd1, 6'sd30, 1'b0);
    check("t3a_done_cyc", 32'(done_cyc), 32'd5);
    check("t3a_collide", 32'(col_s), 32'd0);
    run_op(1'b1, 16'h0066, -5'sd1, 6'sd30, 1'b0);
    check("t3b_done_cyc", 32'(done_cyc), 32'd9);
    check("t3b_wd0", 32'(wd[0]), 32'h0003);
    check("t3b_wa1", 32'(wa[1]), 32'd31);
    clear_board();
    run_op(1'b0, 16'h0066, -5'sd2, 6'sd30, 1'b0);
    check("t3c_collide", 32'(col_s), 32'd1);
    check("t3c_done_cyc", 32'(done_cyc), 32'd5);

    // Right edge: x=13 fits in cols 14..15, x=14 spills to col 16
    run_op(1'b1, 16'h0066, 5'sd13, 6'sd10, 1'b0);
    check("tr_collide", 32'(col_s), 32'd0);
    check("tr_wa0", 32'(wa[0]), 32'd10);
    check("tr_wd0", 32'(wd[0]), 32'hc000);
    run_op(1'b0, 16'h0066, 5'sd14, 6'sd20, 1'b0);
    check("tr_spill_collide", 32'(col_s), 32'd1);

    // Overlap with an occupied cell
    clear_board();
    preload(5'd31, 16'h0002);
    run_op(1'b1, 16'h0066, 5'sd0, 6'sd30, 1'b0);
    check("t4_collide", 32'(col_s), 32'd1);
    check("t4_nwr", 32'(nwr), 32'd0);
    check("t4_done_cyc", 32'(done_cyc), 32'd5);
    check("t4_mem31", 32'(mem[31]), 32'h0002);

    // Test-only request with v_i held high while busy
    clear_board();
    run_op(1'b0, 16'h0066, 5'sd3, 6'sd10, 1'b1);
    check("t5_done_cyc", 32'(done_cyc), 32'd5);
    check("t5_collide", 32'(col_s), 32'd0);
    check("t5_check_v", 32'(chk_s), 32'd0);
    check("t5_nwr", 32'(nwr), 32'd0);
    check("t5_busy_ready", 32'(busy_ready), 32'd0);
    check("t5_ready_after", 32'(bus.ready_o), 32'd1);
    repeat (6) @(posedge clk_i);
    #1;
    check("t5_no_restart", 32'(bus.done_o), 32'd0);

    // Spawn above the board: piece row 0 dropped, row 1 lands on row 0
    clear_board();
    run_op(1'b1, 16'h0066, 5'sd0, -6'sd1, 1'b0);
    check("ty_collide", 32'(col_s), 32'd0);
    check("ty_done_cyc", 32'(done_cyc), 32'd9);
    check("ty_nwr", 32'(nwr), 32'd1);
    check("ty_wa0", 32'(wa[0]), 32'd0);
    check("ty_wc0", 32'(wc[0]), 32'd6);
    check("ty_mem0", 32'(mem[0]), 32'h0006);

    // Reset during the second write cycle
    clear_board();
    bus.v_i = 1'b1; bus.commit_i = 1'b1; bus.piece_i = 16'h0066; bus.x_i = 5'sd0; bus.y_i = 6'sd30;
    @(posedge clk_i); #1;
    bus.v_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    check("t6_pre_write_v", 32'(bus.mm_write_v_o), 32'd1);
    check("t6_pre_waddr", 32'(bus.mm_write_addr_o), 32'd31);
    reset_n_i = 1'b0;
    #1;
    check("t6_write_v", 32'(bus.mm_write_v_o), 32'd0);
    check("t6_ready", 32'(bus.ready_o), 32'd1);
    check("t6_done", 32'(bus.done_o), 32'd0);
    check("t6_raddr", 32'(bus.mm_read_addr_o), 32'd0);
    check("t6_wdata", 32'(bus.mm_write_data_o), 32'd0);
    #1;
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    check("t6_ready_after", 32'(bus.ready_o), 32'd1);
    check("t6_done_after", 32'(bus.done_o), 32'd0);
    check("t6_mem30", 32'(mem[30]), 32'h0006);
    check("t6_mem31", 32'(mem[31]), 32'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
